// File: rtl/ps2_rx_deframer_pkg.sv
// ---------------------------------------------------------------------------
// ps2_rx_deframer_pkg
// Shared definitions for the PS/2 receive deframer:
//   - deframer state encoding
//   - rxErrCode values
//   - bit positions of the PS/2 lines inside ps2_clkdat_i
//   - default idle timeout and timer width
//   - odd-parity helper
// ---------------------------------------------------------------------------
package ps2_rx_deframer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rxState_t;

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAMING = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int PS2_CLK_BIT = 1;
    localparam int PS2_DAT_BIT = 0;

    localparam int TIMEOUT_W           = 16;
    localparam int DEFAULT_TIMEOUT_CYC = 65535;

    // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
        return ^{dataByte, parityBit};
    endfunction

endpackage

// File: rtl/ps2_rx_deframer_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 line: SYNC_STAGES-deep synchroniser followed by an
// optional glitch filter. All flops reset to 1 because the bus idles high.
//
// Optional feature: PS2_RX_GLITCH_FILTER_EN
//   defined   - the filtered output only follows the synchronised line after
//               it has disagreed for FILT_LEN consecutive cycles
//   undefined - the filtered output is the last synchroniser stage
//
// Ports:
//   clock     in   core clock
//   reset     in   asynchronous active-high reset
//   rawLine   in   raw asynchronous line
//   filtLine  out  synchronised (and optionally filtered) line
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2
`ifdef PS2_RX_GLITCH_FILTER_EN
    ,
    parameter int FILT_LEN    = 8
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic rawLine,
    output logic filtLine
);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   syncOut;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            syncReg <= '1;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], rawLine};
        end
    end

    assign syncOut = syncReg[SYNC_STAGES-1];

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic [CNT_W-1:0] filtCnt;
    logic             filtReg;

    // The counter tracks how long the input has disagreed with the output;
    // any agreement restarts the count so short glitches never get through.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filtReg <= 1'b1;
            filtCnt <= '0;
        end else if (syncOut == filtReg) begin
            filtCnt <= '0;
        end else if (filtCnt == CNT_W'(FILT_LEN - 1)) begin
            filtReg <= syncOut;
            filtCnt <= '0;
        end else begin
            filtCnt <= filtCnt + 1'b1;
        end
    end

    assign filtLine = filtReg;
`else
    assign filtLine = syncOut;
`endif

endmodule

// File: rtl/ps2_rx_deframer.sv
// ---------------------------------------------------------------------------
// ps2_rx_deframer
// Receive stage of the PS/2 keyboard block. Conditions the raw PS/2 clock and
// data lines, deframes 11-bit device-to-host frames (start, 8 data LSB first,
// odd parity, stop) and hands validated bytes to the scan FIFO through a
// single-entry valid/ready hold register.
//
// Optional feature: PS2_RX_GLITCH_FILTER_EN enables the per-line glitch
// filter (FILT_LEN parameter only exists in that build).
//
// Ports:
//   clock         in   core clock
//   reset         in   asynchronous active-high reset
//   ps2_clkdat_i  in   raw PS/2 lines, [1]=clock, [0]=data
//   rxData        out  received scancode, valid while rxValid=1
//   rxValid       out  hold register full
//   rxReady       in   consumer takes rxData this cycle when rxValid=1
//   rxErr         out  one-cycle error pulse
//   rxErrCode     out  error cause: 00 overrun, 01 parity, 10 framing, 11 timeout
//   rxBusy        out  deframer not in IDLE
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a falling clock edge with data low (start bit)
// DATA    | shifting in the 8 data bits, LSB first
// PARITY  | waiting for the parity bit
// STOP    | waiting for the stop bit; frame is checked and completed here
// ---------------------------------------------------------------------------
module ps2_rx_deframer
    import ps2_rx_deframer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
`ifdef PS2_RX_GLITCH_FILTER_EN
    parameter int FILT_LEN    = 8,
`endif
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] ps2_clkdat_i,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       rxErr,
    output logic [1:0] rxErrCode,
    output logic       rxBusy
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(TIMEOUT_CYC);

    logic clkFilt;
    logic datFilt;
    logic clkPrev;
    logic fallEdge;

    rxState_t state;
    rxState_t stateNext;

    logic [2:0]           bitCnt;
    logic [7:0]           shiftReg;
    logic                 parityBit;
    logic [TIMEOUT_W-1:0] toCnt;

    logic       bitCntClr;
    logic       bitCntInc;
    logic       shiftEn;
    logic       parityLoad;
    logic       toLoad;
    logic       deliver;
    logic       errPulse;
    logic [1:0] errCodeNext;

    // ---------------------------------------------------------------------
    // Line conditioning
    // ---------------------------------------------------------------------
    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef PS2_RX_GLITCH_FILTER_EN
        ,
        .FILT_LEN    (FILT_LEN)
`endif
    ) uClkFilter (
        .clock    (clock),
        .reset    (reset),
        .rawLine  (ps2_clkdat_i[PS2_CLK_BIT]),
        .filtLine (clkFilt)
    );

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef PS2_RX_GLITCH_FILTER_EN
        ,
        .FILT_LEN    (FILT_LEN)
`endif
    ) uDatFilter (
        .clock    (clock),
        .reset    (reset),
        .rawLine  (ps2_clkdat_i[PS2_DAT_BIT]),
        .filtLine (datFilt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clkPrev <= 1'b1;
        end else begin
            clkPrev <= clkFilt;
        end
    end

    // Data is sampled in the same cycle the edge is seen, so both lines share
    // identical conditioning latency.
    assign fallEdge = clkPrev & ~clkFilt;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and datapath controls
    // ---------------------------------------------------------------------
    always_comb begin
        stateNext   = state;
        bitCntClr   = 1'b0;
        bitCntInc   = 1'b0;
        shiftEn     = 1'b0;
        parityLoad  = 1'b0;
        toLoad      = 1'b0;
        deliver     = 1'b0;
        errPulse    = 1'b0;
        errCodeNext = ERR_OVERRUN;

        case (state)
            IDLE: begin
                // An edge with data high is line noise, not a start bit.
                if (fallEdge && !datFilt) begin
                    stateNext = DATA;
                    bitCntClr = 1'b1;
                    toLoad    = 1'b1;
                end
            end
            DATA: begin
                if (fallEdge) begin
                    shiftEn = 1'b1;
                    toLoad  = 1'b1;
                    if (bitCnt == 3'd7) begin
                        stateNext = PARITY;
                    end else begin
                        bitCntInc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (fallEdge) begin
                    parityLoad = 1'b1;
                    toLoad     = 1'b1;
                    stateNext  = STOP;
                end
            end
            STOP: begin
                if (fallEdge) begin
                    toLoad    = 1'b1;
                    stateNext = IDLE;
                    if (!datFilt) begin
                        errPulse    = 1'b1;
                        errCodeNext = ERR_FRAMING;
                    end else if (!oddParityOk(shiftReg, parityBit)) begin
                        errPulse    = 1'b1;
                        errCodeNext = ERR_PARITY;
                    end else if (rxValid && !rxReady) begin
                        errPulse    = 1'b1;
                        errCodeNext = ERR_OVERRUN;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // A late edge still counts: the timeout only wins when no edge arrives.
        if ((state != IDLE) && !fallEdge && (toCnt == '0)) begin
            stateNext   = IDLE;
            errPulse    = 1'b1;
            errCodeNext = ERR_TIMEOUT;
        end
    end

    // ---------------------------------------------------------------------
    // Frame datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
        end else begin
            if (bitCntClr) begin
                bitCnt <= '0;
            end else if (bitCntInc) begin
                bitCnt <= bitCnt + 3'd1;
            end
            if (shiftEn) begin
                shiftReg <= {datFilt, shiftReg[7:1]};
            end
            if (parityLoad) begin
                parityBit <= datFilt;
            end
        end
    end

    // Inter-edge timeout, a down-counter with terminal count at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            toCnt <= '0;
        end else if (toLoad) begin
            toCnt <= TIMEOUT_LOAD;
        end else if ((state != IDLE) && (toCnt != '0)) begin
            toCnt <= toCnt - 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Hold register and status outputs
    // ---------------------------------------------------------------------
    // A delivery in the same cycle as a consumer pop reloads the register,
    // so delivery takes priority over the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxData  <= '0;
            rxValid <= 1'b0;
        end else if (deliver) begin
            rxData  <= shiftReg;
            rxValid <= 1'b1;
        end else if (rxValid && rxReady) begin
            rxValid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxErr     <= 1'b0;
            rxErrCode <= ERR_OVERRUN;
            rxBusy    <= 1'b0;
        end else begin
            rxErr  <= errPulse;
            rxBusy <= (stateNext != IDLE);
            if (errPulse) begin
                rxErrCode <= errCodeNext;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_deframer.sv
module tb_ps2_rx_deframer;

    localparam int TB_TIMEOUT = 4000;
`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int EDGE_LAT = 2 + 8;
`else
    localparam int EDGE_LAT = 2;
`endif

    logic       clock;
    logic       reset;
    logic       ps2Clk;
    logic       ps2Dat;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic       rxErr;
    logic [1:0] rxErrCode;
    logic       rxBusy;

    ps2_rx_deframer #(
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ps2_clkdat_i ({ps2Clk, ps2Dat}),
        .rxData       (rxData),
        .rxValid      (rxValid),
        .rxReady      (rxReady),
        .rxErr        (rxErr),
        .rxErrCode    (rxErrCode),
        .rxBusy       (rxBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checkCnt = 0;
    int errCnt   = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled away from the active edge.
    int         errTotal    = 0;
    int         validRises  = 0;
    int         errRun      = 0;
    int         errRunMax   = 0;
    logic [1:0] lastErrCode = 2'b00;
    logic       validPrev   = 1'b0;

    always @(negedge clock) begin
        if (rxErr) begin
            errTotal++;
            lastErrCode = rxErrCode;
            errRun++;
        end else begin
            errRun = 0;
        end
        if (errRun > errRunMax) errRunMax = errRun;
        if (rxValid && !validPrev) validRises++;
        validPrev = rxValid;
    end

    // Snapshots taken around the stop-bit edge.
    logic       validBefore;
    logic       validAtLat;
    logic [7:0] dataAtLat;
    logic       validAfter;

    function automatic logic [10:0] mkFrame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Drives frame bits firstBit..lastBit at a 40-cycle half period. When the
    // stop bit is sent, snapshots are taken relative to the edge detection
    // cycle; readyAtStop pulses rxReady exactly in the processing cycle.
    task automatic sendBits(input logic [10:0] frame, input int firstBit, input int lastBit,
                            input bit readyAtStop);
        for (int i = firstBit; i <= lastBit; i++) begin
            ps2Dat = frame[i];
            repeat (20) @(negedge clock);
            ps2Clk = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clock);
                if (i == 10) begin
                    if (k == EDGE_LAT) begin
                        validBefore = rxValid;
                        if (readyAtStop) rxReady = 1'b1;
                    end
                    if (k == EDGE_LAT + 1) begin
                        validAtLat = rxValid;
                        dataAtLat  = rxData;
                        if (readyAtStop) rxReady = 1'b0;
                    end
                    if (k == EDGE_LAT + 2) validAfter = rxValid;
                end
            end
            ps2Clk = 1'b1;
            repeat (20) @(negedge clock);
        end
        ps2Dat = 1'b1;
    endtask

    int  e0;
    int  v0;
    int  waited;
    bit  seen;

    initial begin
        reset   = 1'b1;
        ps2Clk  = 1'b1;
        ps2Dat  = 1'b1;
        rxReady = 1'b0;
        repeat (3) @(negedge clock);
        checkVal("rstData",  32'(rxData),    32'h00);
        checkVal("rstValid", 32'(rxValid),   32'h0);
        checkVal("rstErr",   32'(rxErr),     32'h0);
        checkVal("rstCode",  32'(rxErrCode), 32'h0);
        checkVal("rstBusy",  32'(rxBusy),    32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Scancode 0x1C delivery with consumer always ready.
        rxReady = 1'b1;
        e0 = errTotal;
        v0 = validRises;
        sendBits(mkFrame(8'h1C, 1'b0, 1'b1), 0, 0, 1'b0);
        checkVal("busyMidFrame", 32'(rxBusy), 32'h1);
        sendBits(mkFrame(8'h1C, 1'b0, 1'b1), 1, 10, 1'b0);
        checkVal("dlvValidBefore", 32'(validBefore), 32'h0);
        checkVal("dlvValidLat",    32'(validAtLat),  32'h1);
        checkVal("dlvData",        32'(dataAtLat),   32'h1C);
        checkVal("dlvValidPopped", 32'(validAfter),  32'h0);
        checkVal("dlvValidCount",  32'(validRises - v0), 32'd1);
        checkVal("dlvNoErr",       32'(errTotal - e0),   32'd0);
        checkVal("dlvBusyDone",    32'(rxBusy),      32'h0);

`ifdef PS2_RX_GLITCH_FILTER_EN
        // Short clock glitch with data low must not start a frame.
        e0 = errTotal;
        ps2Dat = 1'b0;
        repeat (5) @(negedge clock);
        ps2Clk = 1'b0;
        repeat (3) @(negedge clock);
        ps2Clk = 1'b1;
        repeat (20) @(negedge clock);
        checkVal("glitchBusy", 32'(rxBusy), 32'h0);
        ps2Dat = 1'b1;
        repeat (20) @(negedge clock);
        checkVal("glitchNoErr", 32'(errTotal - e0), 32'd0);
`endif

        // Parity error: 0x1C with parity 1.
        e0 = errTotal;
        v0 = validRises;
        sendBits(mkFrame(8'h1C, 1'b1, 1'b1), 0, 10, 1'b0);
        checkVal("parErrCount", 32'(errTotal - e0),   32'd1);
        checkVal("parErrCode",  32'(lastErrCode),     32'h1);
        checkVal("parNoValid",  32'(validRises - v0), 32'd0);

        // Framing error: 0xF0 with stop 0.
        e0 = errTotal;
        v0 = validRises;
        sendBits(mkFrame(8'hF0, 1'b1, 1'b0), 0, 10, 1'b0);
        checkVal("frmErrCount", 32'(errTotal - e0),   32'd1);
        checkVal("frmErrCode",  32'(lastErrCode),     32'h2);
        checkVal("frmNoValid",  32'(validRises - v0), 32'd0);
        repeat (20) @(negedge clock);

        // Timeout: five bits then the clock stays high.
        e0 = errTotal;
        sendBits(mkFrame(8'hF0, 1'b1, 1'b1), 0, 4, 1'b0);
        checkVal("toBusyBefore", 32'(rxBusy), 32'h1);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < TB_TIMEOUT + 200) begin
            @(negedge clock);
            waited++;
            if (rxErr) seen = 1'b1;
        end
        checkVal("toSeen",   32'(seen),      32'h1);
        checkVal("toCode",   32'(rxErrCode), 32'h3);
        checkVal("toBusy",   32'(rxBusy),    32'h0);
        checkVal("toWindow", 32'((waited >= TB_TIMEOUT - 80) && (waited <= TB_TIMEOUT)), 32'h1);
        repeat (20) @(negedge clock);
        checkVal("toErrCount", 32'(errTotal - e0), 32'd1);
        sendBits(mkFrame(8'hF0, 1'b1, 1'b1), 0, 10, 1'b0);
        checkVal("toRecoverValid", 32'(validAtLat), 32'h1);
        checkVal("toRecoverData",  32'(dataAtLat),  32'hF0);

        // Overrun: consumer stalled.
        rxReady = 1'b0;
        e0 = errTotal;
        sendBits(mkFrame(8'h1C, 1'b0, 1'b1), 0, 10, 1'b0);
        checkVal("ovrFirstValid", 32'(rxValid), 32'h1);
        checkVal("ovrFirstData",  32'(rxData),  32'h1C);
        sendBits(mkFrame(8'h32, 1'b0, 1'b1), 0, 10, 1'b0);
        checkVal("ovrErrCount", 32'(errTotal - e0), 32'd1);
        checkVal("ovrErrCode",  32'(lastErrCode),   32'h0);
        checkVal("ovrDataHeld", 32'(rxData),        32'h1C);
        checkVal("ovrValidHeld", 32'(rxValid),      32'h1);

        // Frame completing in the same cycle as a pop loads without overrun.
        e0 = errTotal;
        sendBits(mkFrame(8'hF0, 1'b1, 1'b1), 0, 10, 1'b1);
        checkVal("popLoadNoErr", 32'(errTotal - e0), 32'd0);
        checkVal("popLoadValid", 32'(validAtLat),    32'h1);
        checkVal("popLoadData",  32'(dataAtLat),     32'hF0);

        @(negedge clock);
        rxReady = 1'b1;
        @(negedge clock);
        rxReady = 1'b0;
        checkVal("popClearsValid", 32'(rxValid), 32'h0);

        // Reset in the middle of a frame with a byte held.
        sendBits(mkFrame(8'h1C, 1'b0, 1'b1), 0, 10, 1'b0);
        checkVal("preRstValid", 32'(rxValid), 32'h1);
        sendBits(mkFrame(8'h32, 1'b0, 1'b1), 0, 3, 1'b0);
        checkVal("preRstBusy", 32'(rxBusy), 32'h1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkVal("midRstData",  32'(rxData),    32'h00);
        checkVal("midRstValid", 32'(rxValid),   32'h0);
        checkVal("midRstBusy",  32'(rxBusy),    32'h0);
        checkVal("midRstErr",   32'(rxErr),     32'h0);
        checkVal("midRstCode",  32'(rxErrCode), 32'h0);
        ps2Clk = 1'b1;
        ps2Dat = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        rxReady = 1'b1;
        e0 = errTotal;
        sendBits(mkFrame(8'h1C, 1'b0, 1'b1), 0, 10, 1'b0);
        checkVal("postRstValid", 32'(validAtLat),     32'h1);
        checkVal("postRstData",  32'(dataAtLat),      32'h1C);
        checkVal("postRstNoErr", 32'(errTotal - e0),  32'd0);

        checkVal("errPulseWidth", 32'(errRunMax), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/ps2_rx_deframer.md
Name: ps2_rx_deframer

Overview:
- Upstream receive stage for the PS/2 keyboard MMIO block.
- Takes the raw PS/2 clock/data pins and synchronises them, then filters them.
- Deframes 11-bit device-to-host frames: start, 8 data bits LSB first, odd parity, stop.
- Presents validated scancode bytes over a single-entry valid/ready hold register; the keyboard block's scan FIFO consumes them.

Parameters:
- SYNC_STAGES, 2, flip-flop synchroniser depth per line (min 2).
- FILT_LEN, 8, consecutive stable cycles needed before a filtered line changes (only with the macro below).
- TIMEOUT_CYC, 65535, idle cycles between falling clock edges before an in-progress frame is aborted (fits 16 bits).

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clkdat_i  in  2  raw PS/2 lines; bit 1 = clock, bit 0 = data.
- rxData  out  8  received scancode; valid while rxValid=1.
- rxValid  out  1  hold register full.
- rxReady  in  1  consumer accepts rxData this cycle when rxValid=1.
- rxErr  out  1  one-cycle error pulse.
- rxErrCode  out  2  error cause, valid with rxErr: 00 overrun, 01 parity, 10 framing (stop=0), 11 timeout.
- rxBusy  out  1  state machine not in IDLE.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high. While reset is high, all state returns to its reset value immediately.
- Reset values: rxData=0, rxValid=0, rxErr=0, rxErrCode=0, rxBusy=0, state=IDLE, bit counter=0, timeout counter=0. The synchroniser and filter flops reset to 1 (idle-high bus).
- Line conditioning:
  - Each line passes through SYNC_STAGES flops, then the optional filter.
  - A falling edge is filtered clock at 1 in the previous cycle and 0 in the current cycle.
  - Data is sampled from filtered data in the same cycle the edge is detected.
- States:
  - IDLE: on an edge with data=0 go to DATA with bitcnt=0. On an edge with data=1 stay in IDLE; no error.
  - DATA: on each edge shift the data bit into shift[7] and right-shift. When bitcnt=7, go to PARITY; otherwise increment bitcnt.
  - PARITY: on an edge latch the parity bit and go to STOP.
  - STOP: on an edge, go to IDLE and complete the frame:
    - If stop=0, signal framing error (10).
    - Otherwise, if the 8 data bits plus the parity bit contain an even number of ones, signal parity error (01).
    - Otherwise, deliver the byte.
- Timeout:
  - The counter loads TIMEOUT_CYC on every edge detected outside IDLE, including the start bit.
  - It decrements each cycle while the state is not IDLE.
  - Reaching 0 while not IDLE gives rxErr with code 11 and a return to IDLE.
  - If an edge and zero occur in the same cycle, the edge wins: it is processed and the counter reloads.
- Delivery:
  - The byte is written to rxData, and rxValid is set, on the clock after the stop-bit edge cycle. Latency from stop-bit edge detection to rxValid is 1 cycle.
  - rxValid clears on the cycle after rxValid && rxReady.
  - If a frame completes while rxValid=1 and rxReady=0, the new byte is dropped, rxData is unchanged, and rxErr fires with code 00.
  - If a frame completes in the same cycle as rxReady && rxValid, the new byte loads with no overrun.
- Errors:
  - rxErr lasts exactly 1 cycle, registered.
  - Only one cause is reported per frame, priority framing > parity > overrun.
  - An errored frame never sets rxValid.
- rxBusy = (state != IDLE), registered.

Optional Feature:
- Macro: PS2_RX_GLITCH_FILTER_EN.
- Defined: each synchronised line has a counter. A filtered output changes only after the input differs from it for FILT_LEN consecutive cycles; any agreement resets the counter. This adds FILT_LEN cycles of latency.
- Undefined: the filtered output equals the last synchroniser stage; no counter logic is present.

Decomposition:
- Shared package / defines file:
  - state encodings (IDLE, DATA, PARITY, STOP);
  - rxErrCode constants;
  - PS/2 line bit indices (clock=1, data=0);
  - default TIMEOUT_CYC.
- Sub-module ps2_line_filter: synchroniser plus optional glitch filter for one line, instantiated twice.

Test Plan:
- Scancode delivery: drive frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 40-cycle half period, rxReady=1 → one rxValid with rxData=0x1C, rxErr=0.
- Parity error: same frame with parity=1 → rxErr pulse with rxErrCode=01, rxValid stays 0.
- Framing error: 0xF0 frame (parity 1) with stop=0 → rxErrCode=10, no rxValid.
- Timeout recovery: 5 bits, then clock held high for TIMEOUT_CYC+1 cycles → rxErrCode=11, rxBusy=0. A following valid 0xF0 frame is delivered.
- Overrun: frames 0x1C then 0x32 with rxReady=0 → rxData holds 0x1C and rxErrCode=00 on the second frame. Raise rxReady for 1 cycle → rxValid=0 the next cycle.
- Glitch rejection (macro on, FILT_LEN=8): a 3-cycle low pulse on clock while in IDLE → no state change.
- Reset mid-frame: assert reset after 4 bits → all outputs 0 immediately. After release, a complete 0x1C frame is delivered correctly.
